dram_cmd_sched: RTL and testbench
=================================

Name: dram_cmd_sched

Overview:
- Channel-level command scheduler between the per-bank controllers and the DFI control bus.
- Each cycle it picks at most one bank command (ACT/RD/WR/PRE/REF) from the bank request vectors and returns a one-hot grant.
- It enforces the inter-bank timing constraints t_rrd, t_ccd, t_wtr and t_rtw, then drives the registered DDR2 command onto the DFI control signals.
- Per-bank timing (t_rcd, t_rp, t_ras, t_rfc, t_rtp, t_wtp) remains the bank controllers' responsibility.

Parameters:
- NUM_BANKS, 4, number of bank controllers; power of 2, at most 8.
- BA_W, $clog2(NUM_BANKS), bank address width; must not exceed `DFI_BA_WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- act_req_i / rd_req_i / wr_req_i / pre_req_i / ref_req_i  in  NUM_BANKS each  per-bank command requests
- ra_i  in  NUM_BANKS*`DRAM_RA_WIDTH  per-bank row address; bank b occupies slice b
- ca_i  in  NUM_BANKS*`DRAM_CA_WIDTH  per-bank column address
- act_gnt_o / rd_gnt_o / wr_gnt_o / pre_gnt_o / ref_gnt_o  out  NUM_BANKS each  grants
- t_rrd_i / t_ccd_i / t_wtr_i / t_rtw_i  in  `T_RRD_WIDTH / `T_CCD_WIDTH / `T_WTR_WIDTH / `T_RTW_WIDTH  quasi-static timing, in clocks
- dfi_cke  out  1  clock enable
- dfi_cs_n  out  `DFI_CS_WIDTH  chip select
- dfi_ras_n / dfi_cas_n / dfi_we_n  out  1 each  command strobes
- dfi_ba  out  `DFI_BA_WIDTH  bank address
- dfi_addr  out  `DFI_ADDR_WIDTH  address
- dfi_odt  out  1  on-die termination

Behaviour:
- Reset (async, immediate):
  - dfi_cke=0, dfi_cs_n=all 1s, ras_n/cas_n/we_n=1, ba=0, addr=0, odt=0.
  - All timing counters 0; all round-robin pointers at bank 0.
- cke_en register: set to 1 on the first clk edge after rst_n deasserts; drives dfi_cke. No grant is issued while cke_en=0.
- Grants are combinational from the requests and current state, in the same cycle. At most one grant bit is high across all ten grant vectors.
- Class priority: REF > RD/WR > ACT > PRE.
- REF:
  - Eligible only when ref_req_i is all 1s (every bank precharged and requesting).
  - On grant, ref_gnt_o is all 1s in that single cycle.
- RD and WR form one class (CAS) with a shared round-robin pointer. ACT and PRE each have their own pointer.
- Round-robin rule: search starts at pointer+1 and wraps modulo NUM_BANKS. On a grant to bank b, that class's pointer becomes b.
- A bank asserting several requests is treated per class; only the highest-priority class is considered for it.
- Timing counters:
  - On an ACT grant, cnt_rrd loads max(t_rrd-1,0).
  - On any CAS grant, cnt_ccd loads max(t_ccd-1,0).
  - On a WR grant, cnt_wtr loads max(t_wtr-1,0).
  - On a RD grant, cnt_rtw loads max(t_rtw-1,0).
  - Every counter otherwise decrements and saturates at 0.
  - Eligibility: ACT needs cnt_rrd==0; RD needs cnt_ccd==0 and cnt_wtr==0; WR needs cnt_ccd==0 and cnt_rtw==0.
  - Resulting spacing: grant at T allows the next constrained grant at T+max(t,1).
- Ineligible requests are simply not granted. Requests hold until granted; this block holds no other request state.
- DFI command, registered (launched on the clk edge after the grant cycle; latency 1):
  - ACT: cs_n=0, ras/cas/we=0/1/1, ba=b, addr=ra_i[b].
  - RD: 1/0/1, ba=b, addr=ca_i[b] zero-extended with A10=0.
  - WR: 1/0/0, ba=b, addr as RD.
  - PRE: 0/1/0, ba=b, addr=0 (A10=0, single bank).
  - REF: 0/0/1, ba=0, addr=0.
  - No grant: deselect (cs_n all 1s, strobes 1, ba/addr held).
- cs_n for a command: bit 0 low, all others high.
- dfi_odt is 0 in this revision.
- Width rules: counter compares are unsigned; addresses are zero-extended to `DFI_ADDR_WIDTH.
- Simultaneous requests of the same class from all banks: exactly one grant per cycle, rotating fairly.
- A timing-input change mid-count does not affect counters already loaded.

Decomposition:
- Package sal_sched_pkg holds:
  - cmd_t enum: NOP, ACT, RD, WR, PRE, REF.
  - The {ras_n, cas_n, we_n} encoding constant per cmd_t.
  - A function mapping cmd_t to the strobe encoding.
- Sub-module sal_rr_arb (parameter N): request vector plus pointer in, one-hot grant and valid out.
  - Purely combinational; the pointer register stays in dram_cmd_sched.
  - Instantiated three times: CAS, ACT, PRE.

Test Plan:
1. Reset and cke: hold rst_n=0 for 5 cycles, then release → dfi_cke=0 and cs_n all 1s during reset; cke=1 one edge after release; asserting rst_n=0 mid-command returns all DFI outputs to reset values immediately.
2. ACT spacing: t_rrd=4, act_req_i=4'b1111 held → grants to banks 1,2,3,0 at cycles T, T+4, T+8, T+12; DFI ACT with ba=1 at T+1.
3. CAS turnaround: t_ccd=2, t_wtr=6, t_rtw=3; WR on bank 0 at T plus RD request on bank 1 → RD granted at T+6. Then WR request → WR granted 3 cycles after that RD.
4. Priority: in one cycle, ref_req=1111, rd_req[2]=1, act_req[3]=1 → ref_gnt=1111 only, REF encoding 0/0/1 with addr=0. Next cycle (REF dropped) → rd_gnt[2].
5. Partial refresh: ref_req=0111 with pre_req[3]=1 → pre_gnt[3] granted and no REF until ref_req=1111.
6. Fairness: rd_req=1111 with all timing counters 0 and t_ccd=1 → one grant per cycle, rotating 1,2,3,0,1; never two grant bits high at once.

Source files
------------

// File: rtl/sal_sched_pkg.sv
// -----------------------------------------------------------------------------
// sal_sched_pkg
// Shared types for the DRAM channel command scheduler:
//   - default widths for the DRAM/DFI address, control and timing fields
//     (each can be overridden by defining the macro before this file)
//   - cmd_t, the command chosen in a cycle
//   - the DDR2 {ras_n, cas_n, we_n} strobe encoding for each command
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DFI_ADDR_WIDTH
`define DFI_ADDR_WIDTH 14
`endif
`ifndef DFI_BA_WIDTH
`define DFI_BA_WIDTH 3
`endif
`ifndef DFI_CS_WIDTH
`define DFI_CS_WIDTH 2
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

package sal_sched_pkg;

    typedef enum logic [2:0] {
        NOP,
        ACT,
        RD,
        WR,
        PRE,
        REF
    } cmd_t;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] STB_NOP = 3'b111;
    localparam logic [2:0] STB_ACT = 3'b011;
    localparam logic [2:0] STB_RD  = 3'b101;
    localparam logic [2:0] STB_WR  = 3'b100;
    localparam logic [2:0] STB_PRE = 3'b010;
    localparam logic [2:0] STB_REF = 3'b001;

    function automatic logic [2:0] cmd_strobes(input cmd_t cmd);
        logic [2:0] stb;
        case (cmd)
            ACT:     stb = STB_ACT;
            RD:      stb = STB_RD;
            WR:      stb = STB_WR;
            PRE:     stb = STB_PRE;
            REF:     stb = STB_REF;
            default: stb = STB_NOP;
        endcase
        return stb;
    endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// -----------------------------------------------------------------------------
// sal_rr_arb
// Purely combinational round-robin picker. The search starts at ptr+1 and
// wraps modulo N, so the bank granted last (held in ptr by the caller) has
// the lowest priority next time. N must be a power of two >= 2.
// Ports:
//   req   in  N   request vector
//   ptr   in  PW  index of the most recently granted requester
//   gnt   out N   one-hot grant (all zero when valid=0)
//   valid out 1   some request was granted
// -----------------------------------------------------------------------------
module sal_rr_arb #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            // PW-bit addition wraps naturally because N is a power of two;
            // i == N lands on ptr itself as the last candidate.
            idx = ptr + PW'(i);
            if (!valid && req[idx]) begin
                gnt[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dram_cmd_sched.sv
// -----------------------------------------------------------------------------
// dram_cmd_sched
// Channel-level command scheduler. Each cycle picks at most one bank command
// (REF > RD/WR > ACT > PRE), returns a combinational one-hot grant, enforces
// the inter-bank t_rrd / t_ccd / t_wtr / t_rtw spacing and launches the
// granted command on the DFI control bus one clock later.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   act/rd/wr/pre/ref_req_i [NB]   per-bank requests (held until granted)
//   ra_i  [NB*RA]                  per-bank row address, bank b in slice b
//   ca_i  [NB*CA]                  per-bank column address, bank b in slice b
//   act/rd/wr/pre/ref_gnt_o [NB]   grants, at most one bit high overall
//   t_rrd_i/t_ccd_i/t_wtr_i/t_rtw_i  quasi-static timing in clocks
//   dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr,
//   dfi_odt                        registered DFI control outputs
// -----------------------------------------------------------------------------
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DFI_ADDR_WIDTH
`define DFI_ADDR_WIDTH 14
`endif
`ifndef DFI_BA_WIDTH
`define DFI_BA_WIDTH 3
`endif
`ifndef DFI_CS_WIDTH
`define DFI_CS_WIDTH 2
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

module dram_cmd_sched
    import sal_sched_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = $clog2(NUM_BANKS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_BANKS-1:0]                  act_req_i,
    input  logic [NUM_BANKS-1:0]                  rd_req_i,
    input  logic [NUM_BANKS-1:0]                  wr_req_i,
    input  logic [NUM_BANKS-1:0]                  pre_req_i,
    input  logic [NUM_BANKS-1:0]                  ref_req_i,
    input  logic [NUM_BANKS*`DRAM_RA_WIDTH-1:0]   ra_i,
    input  logic [NUM_BANKS*`DRAM_CA_WIDTH-1:0]   ca_i,
    output logic [NUM_BANKS-1:0]                  act_gnt_o,
    output logic [NUM_BANKS-1:0]                  rd_gnt_o,
    output logic [NUM_BANKS-1:0]                  wr_gnt_o,
    output logic [NUM_BANKS-1:0]                  pre_gnt_o,
    output logic [NUM_BANKS-1:0]                  ref_gnt_o,
    input  logic [`T_RRD_WIDTH-1:0]               t_rrd_i,
    input  logic [`T_CCD_WIDTH-1:0]               t_ccd_i,
    input  logic [`T_WTR_WIDTH-1:0]               t_wtr_i,
    input  logic [`T_RTW_WIDTH-1:0]               t_rtw_i,
    output logic                                  dfi_cke,
    output logic [`DFI_CS_WIDTH-1:0]              dfi_cs_n,
    output logic                                  dfi_ras_n,
    output logic                                  dfi_cas_n,
    output logic                                  dfi_we_n,
    output logic [`DFI_BA_WIDTH-1:0]              dfi_ba,
    output logic [`DFI_ADDR_WIDTH-1:0]            dfi_addr,
    output logic                                  dfi_odt
);

    localparam int RA_W   = `DRAM_RA_WIDTH;
    localparam int CA_W   = `DRAM_CA_WIDTH;
    localparam int ADDR_W = `DFI_ADDR_WIDTH;
    localparam int DBA_W  = `DFI_BA_WIDTH;
    localparam int CS_W   = `DFI_CS_WIDTH;

    // Rank 0 selected: bit 0 low, every other chip select high.
    localparam logic [CS_W-1:0] CS_SEL = ~(CS_W'(1));

    logic                     cke_en;
    logic [BA_W-1:0]          ptr_cas, ptr_act, ptr_pre;
    logic [`T_RRD_WIDTH-1:0]  cnt_rrd;
    logic [`T_CCD_WIDTH-1:0]  cnt_ccd;
    logic [`T_WTR_WIDTH-1:0]  cnt_wtr;
    logic [`T_RTW_WIDTH-1:0]  cnt_rtw;

    logic                     act_ok, rd_ok, wr_ok;
    logic [NUM_BANKS-1:0]     cas_raw, cas_elig, act_elig, pre_elig;
    logic [NUM_BANKS-1:0]     cas_oh, act_oh, pre_oh;
    logic                     cas_vld, act_vld, pre_vld;
    cmd_t                     cmd;
    logic [BA_W-1:0]          sel;
    logic [RA_W-1:0]          sel_ra;
    logic [CA_W-1:0]          sel_ca;

    function automatic logic [BA_W-1:0] oh_to_idx(input logic [NUM_BANKS-1:0] oh);
        logic [BA_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (oh[i]) idx = idx | BA_W'(i);
        end
        return idx;
    endfunction

    assign act_ok = (cnt_rrd == '0);
    assign rd_ok  = (cnt_ccd == '0) && (cnt_wtr == '0);
    assign wr_ok  = (cnt_ccd == '0) && (cnt_rtw == '0);

    // A bank's lower-class requests are masked by any higher-class request it
    // raises, whether or not that higher request is currently eligible.
    assign cas_raw  = rd_req_i | wr_req_i;
    assign cas_elig = (rd_req_i & {NUM_BANKS{rd_ok}}) | (wr_req_i & {NUM_BANKS{wr_ok}});
    assign act_elig = act_req_i & ~cas_raw & {NUM_BANKS{act_ok}};
    assign pre_elig = pre_req_i & ~cas_raw & ~act_req_i;

    sal_rr_arb #(.N(NUM_BANKS)) u_arb_cas (.req(cas_elig), .ptr(ptr_cas), .gnt(cas_oh), .valid(cas_vld));
    sal_rr_arb #(.N(NUM_BANKS)) u_arb_act (.req(act_elig), .ptr(ptr_act), .gnt(act_oh), .valid(act_vld));
    sal_rr_arb #(.N(NUM_BANKS)) u_arb_pre (.req(pre_elig), .ptr(ptr_pre), .gnt(pre_oh), .valid(pre_vld));

    always_comb begin
        act_gnt_o = '0;
        rd_gnt_o  = '0;
        wr_gnt_o  = '0;
        pre_gnt_o = '0;
        ref_gnt_o = '0;
        cmd       = NOP;
        sel       = '0;
        if (cke_en) begin
            if (&ref_req_i) begin
                ref_gnt_o = '1;
                cmd       = REF;
            end else if (cas_vld) begin
                sel = oh_to_idx(cas_oh);
                // Bank with both RD and WR pending: RD wins when legal.
                if (rd_req_i[sel] && rd_ok) begin
                    rd_gnt_o = cas_oh;
                    cmd      = RD;
                end else begin
                    wr_gnt_o = cas_oh;
                    cmd      = WR;
                end
            end else if (act_vld) begin
                sel       = oh_to_idx(act_oh);
                act_gnt_o = act_oh;
                cmd       = ACT;
            end else if (pre_vld) begin
                sel       = oh_to_idx(pre_oh);
                pre_gnt_o = pre_oh;
                cmd       = PRE;
            end
        end
    end

    assign sel_ra  = ra_i[int'(sel)*RA_W +: RA_W];
    assign sel_ca  = ca_i[int'(sel)*CA_W +: CA_W];
    assign dfi_cke = cke_en;
    assign dfi_odt = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cke_en    <= 1'b0;
            ptr_cas   <= '0;
            ptr_act   <= '0;
            ptr_pre   <= '0;
            cnt_rrd   <= '0;
            cnt_ccd   <= '0;
            cnt_wtr   <= '0;
            cnt_rtw   <= '0;
            dfi_cs_n  <= '1;
            dfi_ras_n <= 1'b1;
            dfi_cas_n <= 1'b1;
            dfi_we_n  <= 1'b1;
            dfi_ba    <= '0;
            dfi_addr  <= '0;
        end else begin
            cke_en <= 1'b1;

            // Timing counters: load t-1 (floored at 0) on grant, else count down.
            if (cmd == ACT)
                cnt_rrd <= (t_rrd_i == '0) ? '0 : t_rrd_i - 1'b1;
            else if (cnt_rrd != '0)
                cnt_rrd <= cnt_rrd - 1'b1;

            if (cmd == RD || cmd == WR)
                cnt_ccd <= (t_ccd_i == '0) ? '0 : t_ccd_i - 1'b1;
            else if (cnt_ccd != '0)
                cnt_ccd <= cnt_ccd - 1'b1;

            if (cmd == WR)
                cnt_wtr <= (t_wtr_i == '0) ? '0 : t_wtr_i - 1'b1;
            else if (cnt_wtr != '0)
                cnt_wtr <= cnt_wtr - 1'b1;

            if (cmd == RD)
                cnt_rtw <= (t_rtw_i == '0) ? '0 : t_rtw_i - 1'b1;
            else if (cnt_rtw != '0)
                cnt_rtw <= cnt_rtw - 1'b1;

            if (cmd == RD || cmd == WR) ptr_cas <= sel;
            if (cmd == ACT)             ptr_act <= sel;
            if (cmd == PRE)             ptr_pre <= sel;

            {dfi_ras_n, dfi_cas_n, dfi_we_n} <= cmd_strobes(cmd);
            dfi_cs_n <= (cmd == NOP) ? '1 : CS_SEL;
            case (cmd)
                ACT: begin
                    dfi_ba   <= DBA_W'(sel);
                    dfi_addr <= ADDR_W'(sel_ra);
                end
                RD, WR: begin
                    // Column sits below A10, so zero-extension keeps A10=0.
                    dfi_ba   <= DBA_W'(sel);
                    dfi_addr <= ADDR_W'(sel_ca);
                end
                PRE: begin
                    dfi_ba   <= DBA_W'(sel);
                    dfi_addr <= '0;
                end
                REF: begin
                    dfi_ba   <= '0;
                    dfi_addr <= '0;
                end
                default: ;  // deselect: ba/addr hold
            endcase
        end
    end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_dram_cmd_sched
// Self-checking bench for dram_cmd_sched. The reference model tracks the
// earliest cycle at which each timing-constrained command may issue and picks
// grants by class priority and round-robin order; expected DFI words are
// queued in exp_q and popped one clock after the grant.
// -----------------------------------------------------------------------------
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef DFI_ADDR_WIDTH
`define DFI_ADDR_WIDTH 14
`endif
`ifndef DFI_BA_WIDTH
`define DFI_BA_WIDTH 3
`endif
`ifndef DFI_CS_WIDTH
`define DFI_CS_WIDTH 2
`endif
`ifndef T_RRD_WIDTH
`define T_RRD_WIDTH 4
`endif
`ifndef T_CCD_WIDTH
`define T_CCD_WIDTH 4
`endif
`ifndef T_WTR_WIDTH
`define T_WTR_WIDTH 4
`endif
`ifndef T_RTW_WIDTH
`define T_RTW_WIDTH 4
`endif

module tb_dram_cmd_sched;

    localparam int N      = 4;
    localparam int RA_W   = `DRAM_RA_WIDTH;
    localparam int CA_W   = `DRAM_CA_WIDTH;
    localparam int ADDR_W = `DFI_ADDR_WIDTH;
    localparam int DBA_W  = `DFI_BA_WIDTH;
    localparam int CS_W   = `DFI_CS_WIDTH;
    localparam int DW     = 1 + CS_W + 3 + DBA_W + ADDR_W + 1;
    localparam int GW     = 5 * N;
    localparam logic [DW-1:0] RST_WORD = {1'b0, {CS_W{1'b1}}, 3'b111, {DBA_W{1'b0}}, {ADDR_W{1'b0}}, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]             act_req, rd_req, wr_req, pre_req, ref_req;
    logic [N*RA_W-1:0]        ra;
    logic [N*CA_W-1:0]        ca;
    logic [N-1:0]             act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [`T_RRD_WIDTH-1:0]  t_rrd;
    logic [`T_CCD_WIDTH-1:0]  t_ccd;
    logic [`T_WTR_WIDTH-1:0]  t_wtr;
    logic [`T_RTW_WIDTH-1:0]  t_rtw;
    logic                     dfi_cke, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt;
    logic [CS_W-1:0]          dfi_cs_n;
    logic [DBA_W-1:0]         dfi_ba;
    logic [ADDR_W-1:0]        dfi_addr;

    dram_cmd_sched #(.NUM_BANKS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .act_req_i (act_req),
        .rd_req_i  (rd_req),
        .wr_req_i  (wr_req),
        .pre_req_i (pre_req),
        .ref_req_i (ref_req),
        .ra_i      (ra),
        .ca_i      (ca),
        .act_gnt_o (act_gnt),
        .rd_gnt_o  (rd_gnt),
        .wr_gnt_o  (wr_gnt),
        .pre_gnt_o (pre_gnt),
        .ref_gnt_o (ref_gnt),
        .t_rrd_i   (t_rrd),
        .t_ccd_i   (t_ccd),
        .t_wtr_i   (t_wtr),
        .t_rtw_i   (t_rtw),
        .dfi_cke   (dfi_cke),
        .dfi_cs_n  (dfi_cs_n),
        .dfi_ras_n (dfi_ras_n),
        .dfi_cas_n (dfi_cas_n),
        .dfi_we_n  (dfi_we_n),
        .dfi_ba    (dfi_ba),
        .dfi_addr  (dfi_addr),
        .dfi_odt   (dfi_odt)
    );

    wire [GW-1:0] gnt_all = {ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt};
    wire [DW-1:0] dfi_all = {dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_ba, dfi_addr, dfi_odt};

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    int  cyc = 0;
    int  act_rdy, cas_rdy, rd_rdy, wr_rdy;   // earliest legal cycle
    int  p_cas, p_act, p_pre;                // last granted bank per class
    bit  cke_on;
    logic [DBA_W-1:0]  m_ba;
    logic [ADDR_W-1:0] m_addr;
    logic [DW-1:0]     exp_q[$];

    function automatic int mx1(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 1; i <= N; i++) begin
            int idx = (p + i) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        act_rdy = 0; cas_rdy = 0; rd_rdy = 0; wr_rdy = 0;
        p_cas = 0; p_act = 0; p_pre = 0;
        cke_on = 1'b0;
        m_ba = '0; m_addr = '0;
        exp_q.delete();
    endtask

    // Evaluate one cycle with the inputs currently applied; returns expected
    // grants and queues the DFI word expected after the following edge.
    task automatic model_step(output logic [GW-1:0] eg);
        logic [N-1:0] g_act, g_rd, g_wr, g_pre, g_ref, c_cas, c_act, c_pre;
        logic [2:0] stb;
        logic [CS_W-1:0] cs;
        int b;
        bit rd_ok, wr_ok;
        g_act = '0; g_rd = '0; g_wr = '0; g_pre = '0; g_ref = '0;
        stb = 3'b111; cs = '1; b = -1;
        rd_ok = (cyc >= cas_rdy) && (cyc >= rd_rdy);
        wr_ok = (cyc >= cas_rdy) && (cyc >= wr_rdy);
        for (int i = 0; i < N; i++) begin
            c_cas[i] = (rd_req[i] && rd_ok) || (wr_req[i] && wr_ok);
            c_act[i] = act_req[i] && !rd_req[i] && !wr_req[i] && (cyc >= act_rdy);
            c_pre[i] = pre_req[i] && !rd_req[i] && !wr_req[i] && !act_req[i];
        end
        if (cke_on) begin
            if (ref_req == '1) begin
                g_ref = '1; stb = 3'b001; cs[0] = 1'b0; m_ba = '0; m_addr = '0;
            end else if (c_cas != '0) begin
                b = rr_pick(c_cas, p_cas); p_cas = b;
                cas_rdy = cyc + mx1(int'(t_ccd));
                cs[0] = 1'b0; m_ba = DBA_W'(b); m_addr = ADDR_W'(ca[b*CA_W +: CA_W]);
                if (rd_req[b] && rd_ok) begin
                    g_rd[b] = 1'b1; stb = 3'b101; wr_rdy = cyc + mx1(int'(t_rtw));
                end else begin
                    g_wr[b] = 1'b1; stb = 3'b100; rd_rdy = cyc + mx1(int'(t_wtr));
                end
            end else if (c_act != '0) begin
                b = rr_pick(c_act, p_act); p_act = b;
                act_rdy = cyc + mx1(int'(t_rrd));
                g_act[b] = 1'b1; stb = 3'b011; cs[0] = 1'b0;
                m_ba = DBA_W'(b); m_addr = ADDR_W'(ra[b*RA_W +: RA_W]);
            end else if (c_pre != '0) begin
                b = rr_pick(c_pre, p_pre); p_pre = b;
                g_pre[b] = 1'b1; stb = 3'b010; cs[0] = 1'b0;
                m_ba = DBA_W'(b); m_addr = '0;
            end
        end
        exp_q.push_back({1'b1, cs, stb, m_ba, m_addr, 1'b0});
        eg = {g_ref, g_pre, g_wr, g_rd, g_act};
        cyc++;
        cke_on = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_reqs();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    endtask

    task automatic rand_addr();
        for (int b = 0; b < N; b++) begin
            ra[b*RA_W +: RA_W] = RA_W'($urandom);
            ca[b*CA_W +: CA_W] = CA_W'($urandom);
        end
    endtask

    // Reset, release, and let cke come up so the next cycle can grant.
    task automatic do_reset();
        clear_reqs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        cke_on = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [GW-1:0] eg;
        logic [DW-1:0] ed;
        clear_reqs();
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        rand_addr();
        act_req = '1;
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if (dfi_all !== RST_WORD || gnt_all !== '0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: dfi %h gnt %h, want dfi %h gnt 0", k, dfi_all, gnt_all, RST_WORD);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            model_step(eg);
            n_checks++;
            if (gnt_all !== eg) begin
                n_fail++;
                $display("FAIL reset_release gnt cyc %0d: got %h want %h", k, gnt_all, eg);
            end
            @(posedge clk); #1;
            ed = exp_q.pop_front();
            n_checks++;
            if (dfi_all !== ed || dfi_cke !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_release dfi cyc %0d: got %h want %h", k, dfi_all, ed);
            end
        end
        // An ACT is on the bus now; reset must clear it without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dfi_all !== RST_WORD) begin
            n_fail++;
            $display("FAIL reset_midcmd: got %h want %h", dfi_all, RST_WORD);
        end
    endtask

    task automatic test_act_spacing();
        logic [GW-1:0] eg;
        logic [DW-1:0] ed;
        logic [N-1:0]  ea;
        do_reset();
        t_rrd = 4'd4; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        rand_addr();
        act_req = '1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            model_step(eg);
            ea = (k % 4 == 0) ? N'(1 << ((k / 4 + 1) % 4)) : '0;
            n_checks++;
            if (gnt_all !== eg || act_gnt !== ea) begin
                n_fail++;
                $display("FAIL act_spacing gnt cyc %0d: got %h want %h act %b", k, gnt_all, eg, ea);
            end
            @(posedge clk); #1;
            ed = exp_q.pop_front();
            n_checks++;
            if (dfi_all !== ed) begin
                n_fail++;
                $display("FAIL act_spacing dfi cyc %0d: got %h want %h", k, dfi_all, ed);
            end
            if (k == 0) begin
                n_checks++;
                if (dfi_ba !== DBA_W'(1) || {dfi_ras_n, dfi_cas_n, dfi_we_n} !== 3'b011 ||
                    dfi_addr !== ADDR_W'(ra[RA_W +: RA_W])) begin
                    n_fail++;
                    $display("FAIL act_first_dfi: ba %0d strobes %b addr %h, want ba 1 strobes 011", dfi_ba,
                             {dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_addr);
                end
            end
        end
    endtask

    task automatic test_cas_turnaround();
        logic [GW-1:0]  eg;
        logic [DW-1:0]  ed;
        logic [2*N-1:0] ec;
        do_reset();
        t_rrd = '0; t_ccd = 4'd2; t_wtr = 4'd6; t_rtw = 4'd3;
        rand_addr();
        for (int k = 0; k < 11; k++) begin
            clear_reqs();
            if (k == 0)               wr_req = 4'b0001;
            else if (k <= 6)          rd_req = 4'b0010;
            else if (k <= 9)          wr_req = 4'b0001;
            @(negedge clk);
            model_step(eg);
            ec = (k == 0) ? {4'b0001, 4'b0000} : (k == 6) ? {4'b0000, 4'b0010} :
                 (k == 9) ? {4'b0001, 4'b0000} : '0;
            n_checks++;
            if (gnt_all !== eg || {wr_gnt, rd_gnt} !== ec) begin
                n_fail++;
                $display("FAIL cas_turnaround gnt cyc %0d: got %h want %h wr/rd %h", k, gnt_all, eg, ec);
            end
            @(posedge clk); #1;
            ed = exp_q.pop_front();
            n_checks++;
            if (dfi_all !== ed) begin
                n_fail++;
                $display("FAIL cas_turnaround dfi cyc %0d: got %h want %h", k, dfi_all, ed);
            end
        end
    endtask

    task automatic test_priority();
        logic [GW-1:0] eg;
        logic [DW-1:0] ed;
        logic [GW-1:0] ex;
        do_reset();
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        rand_addr();
        for (int k = 0; k < 2; k++) begin
            clear_reqs();
            ref_req = (k == 0) ? 4'b1111 : 4'b0000;
            rd_req  = 4'b0100;
            act_req = 4'b1000;
            @(negedge clk);
            model_step(eg);
            ex = (k == 0) ? {4'b1111, 16'h0} : {12'h0, 4'b0100, 4'b0000};
            n_checks++;
            if (gnt_all !== eg || gnt_all !== ex) begin
                n_fail++;
                $display("FAIL priority gnt cyc %0d: got %h want %h", k, gnt_all, ex);
            end
            @(posedge clk); #1;
            ed = exp_q.pop_front();
            n_checks++;
            if (dfi_all !== ed) begin
                n_fail++;
                $display("FAIL priority dfi cyc %0d: got %h want %h", k, dfi_all, ed);
            end
            if (k == 0) begin
                n_checks++;
                if ({dfi_ras_n, dfi_cas_n, dfi_we_n} !== 3'b001 || dfi_addr !== '0 || dfi_ba !== '0 || dfi_cs_n[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL priority_ref_dfi: strobes %b addr %h ba %0d cs %b, want 001 0 0 cs0=0",
                             {dfi_ras_n, dfi_cas_n, dfi_we_n}, dfi_addr, dfi_ba, dfi_cs_n);
                end
            end
        end
    endtask

    task automatic test_partial_refresh();
        logic [GW-1:0] eg;
        logic [DW-1:0] ed;
        logic [GW-1:0] ex;
        do_reset();
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0;
        for (int k = 0; k < 3; k++) begin
            clear_reqs();
            ref_req = (k == 2) ? 4'b1111 : 4'b0111;
            pre_req = (k == 0) ? 4'b1000 : 4'b0000;
            @(negedge clk);
            model_step(eg);
            ex = (k == 0) ? {4'b0000, 4'b1000, 12'h0} : (k == 2) ? {4'b1111, 16'h0} : '0;
            n_checks++;
            if (gnt_all !== eg || gnt_all !== ex) begin
                n_fail++;
                $display("FAIL partial_refresh gnt cyc %0d: got %h want %h", k, gnt_all, ex);
            end
            @(posedge clk); #1;
            ed = exp_q.pop_front();
            n_checks++;
            if (dfi_all !== ed) begin
                n_fail++;
                $display("FAIL partial_refresh dfi cyc %0d: got %h want %h", k, dfi_all, ed);
            end
        end
    endtask

    task automatic test_fairness();
        logic [GW-1:0] eg;
        logic [DW-1:0] ed;
        do_reset();
        t_rrd = '0; t_ccd = 4'd1; t_wtr = '0; t_rtw = '0;
        rand_addr();
        rd_req = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            model_step(eg);
            n_checks++;
            if (gnt_all !== eg || rd_gnt !== N'(1 << ((k + 1) % 4)) || $countones(gnt_all) != 1) begin
                n_fail++;
                $display("FAIL fairness gnt cyc %0d: got %h want %h", k, gnt_all, eg);
            end
            @(posedge clk); #1;
            ed = exp_q.pop_front();
            n_checks++;
            if (dfi_all !== ed) begin
                n_fail++;
                $display("FAIL fairness dfi cyc %0d: got %h want %h", k, dfi_all, ed);
            end
        end
    endtask

    task automatic test_random();
        logic [GW-1:0] eg;
        logic [DW-1:0] ed;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            // Timing inputs change every so often, including mid-count.
            if (k % 25 == 0) begin
                t_rrd = 4'($urandom_range(0, 7));
                t_ccd = 4'($urandom_range(0, 7));
                t_wtr = 4'($urandom_range(0, 7));
                t_rtw = 4'($urandom_range(0, 7));
            end
            rand_addr();
            act_req = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            rd_req  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            wr_req  = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            pre_req = N'($urandom_range(0, 15));
            ref_req = ($urandom_range(0, 7) == 0) ? '1 : N'($urandom_range(0, 14));
            @(negedge clk);
            model_step(eg);
            n_checks++;
            if (gnt_all !== eg || $countones(gnt_all) > N) begin
                n_fail++;
                $display("FAIL random gnt cyc %0d: got %h want %h", k, gnt_all, eg);
            end
            @(posedge clk); #1;
            ed = exp_q.pop_front();
            n_checks++;
            if (dfi_all !== ed) begin
                n_fail++;
                $display("FAIL random dfi cyc %0d: got %h want %h", k, dfi_all, ed);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_act_spacing();
        test_cas_turnaround();
        test_priority();
        test_partial_refresh();
        test_fairness();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
